// File: rtl/dimc_pkg.sv
// dimc_pkg: shared DIMC feature-path types and constants
package dimc_pkg;
  localparam int DIMC_FEAT_W = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} feat_ld_state_e;
  typedef logic [DIMC_FEAT_W-1:0] feat_word_t;
endpackage

// File: rtl/dimc_feat_loader_if.sv
// dimc_feat_loader_if: upstream and tile-side feature handshakes of the loader
interface dimc_feat_loader_if #(parameter int DATA_W = dimc_pkg::DIMC_FEAT_W);
  logic              s_feat_valid;
  logic              s_feat_ready;
  logic [DATA_W-1:0] s_feat_data;
  logic              m_feat_valid;
  logic              m_feat_ready;
  logic              m_feat_last;
  logic [DATA_W-1:0] m_feat_data;
  modport master(output s_feat_valid, s_feat_data, m_feat_ready,
                 input s_feat_ready, m_feat_valid, m_feat_data, m_feat_last);
  modport slave(input s_feat_valid, s_feat_data, m_feat_ready,
                output s_feat_ready, m_feat_valid, m_feat_data, m_feat_last);
endinterface

// File: rtl/dimc_feat_fifo.sv
// dimc_feat_fifo: sync FIFO, combinational head read, no fall-through
module dimc_feat_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  // storage write; read side only sees it after the edge
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  // pointers and occupancy, cleared by either reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= (push && !pop) ? level + (AW+1)'(1) : (!push && pop) ? level - (AW+1)'(1) : level;
    end
  assign rdata = mem[rd_ptr];
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/dimc_feat_loader.sv
// dimc_feat_loader: buffers feature words and issues valid_feat_count per tile pass
// Optional DIMC_FEAT_LOADER_STATS_EN adds saturating stat_words/stat_bubbles counters.
module dimc_feat_loader
  import dimc_pkg::*;
#(
  parameter int DATA_W = DIMC_FEAT_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                   dimc_tilewrap_clk,
  input  logic                   dimc_tilewrap_rst,
  input  logic                   soft_reset,
  input  logic                   disable_stall,
  input  logic                   feat_en,
  input  logic                   tile_en,
  input  logic [CNT_W-1:0]       valid_feat_count,
  dimc_feat_loader_if.slave      bus,
  output logic                   feat_buff_full,
  output logic                   feat_buff_empty,
  output logic [$clog2(DEPTH):0] feat_buff_level,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   err_underrun
`ifdef DIMC_FEAT_LOADER_STATS_EN
  ,
  output logic [31:0]            stat_words,
  output logic [15:0]            stat_bubbles
`endif
);
  feat_ld_state_e    state, state_nx;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] fifo_head;
  logic              hs, push, pop, start;
  assign hs    = bus.m_feat_valid && bus.m_feat_ready && !soft_reset;
  assign push  = bus.s_feat_valid && !feat_buff_full && !soft_reset;
  assign pop   = hs && !feat_buff_empty;
  assign start = feat_en && tile_en && valid_feat_count != '0;
  dimc_feat_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (dimc_tilewrap_clk),
    .rst   (dimc_tilewrap_rst),
    .clr   (soft_reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_feat_data),
    .rdata (fifo_head),
    .full  (feat_buff_full),
    .empty (feat_buff_empty),
    .level (feat_buff_level)
  );
  // pass state register
  always_ff @(posedge dimc_tilewrap_clk or posedge dimc_tilewrap_rst)
    if (dimc_tilewrap_rst) state <= IDLE;
    else state <= state_nx;
  // pass sequencing: start, abort on tile_en drop, finish on the last handshake
  always_comb
    state_nx = soft_reset ? IDLE :
               state == IDLE  ? (start ? ISSUE : IDLE) :
               state == ISSUE ? (!tile_en ? IDLE : (hs && remaining == CNT_W'(1)) ? DONE : ISSUE) :
               IDLE;
  // words left in the pass; count is sampled only when the pass starts
  always_ff @(posedge dimc_tilewrap_clk or posedge dimc_tilewrap_rst)
    if (dimc_tilewrap_rst) remaining <= '0;
    else if (soft_reset) remaining <= '0;
    else if (state == IDLE && start) remaining <= valid_feat_count;
    else if (state == ISSUE && hs) remaining <= remaining - CNT_W'(1);
  // tile-side outputs; an empty FIFO with disable_stall issues a zero bubble
  always_comb begin
    bus.m_feat_valid = state == ISSUE && feat_en && (!feat_buff_empty || disable_stall);
    bus.m_feat_last  = bus.m_feat_valid && remaining == CNT_W'(1);
    bus.m_feat_data  = feat_buff_empty ? '0 : fifo_head;
    bus.s_feat_ready = !feat_buff_full;
    busy             = state != IDLE;
    done_pulse       = state == DONE;
    err_underrun     = hs && feat_buff_empty;
  end
`ifdef DIMC_FEAT_LOADER_STATS_EN
  // saturating counts of popped words and issued bubbles
  always_ff @(posedge dimc_tilewrap_clk or posedge dimc_tilewrap_rst)
    if (dimc_tilewrap_rst) begin
      stat_words   <= '0;
      stat_bubbles <= '0;
    end else if (soft_reset) begin
      stat_words   <= '0;
      stat_bubbles <= '0;
    end else begin
      if (pop && !(&stat_words)) stat_words <= stat_words + 32'd1;
      if (err_underrun && !(&stat_bubbles)) stat_bubbles <= stat_bubbles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dimc_feat_loader.sv
// tb_dimc_feat_loader: directed stimulus with a queue scoreboard on the tile-side handshake
module tb_dimc_feat_loader;
  import dimc_pkg::*;
  logic       clk = 0, rst = 1, soft_reset = 0, disable_stall = 0, feat_en = 0, tile_en = 0;
  logic [7:0] count = 0;
  logic       full, empty, busy, done, err;
  logic [4:0] level;
`ifdef DIMC_FEAT_LOADER_STATS_EN
  logic [31:0] stat_words;
  logic [15:0] stat_bubbles;
`endif
  typedef struct packed {
    feat_word_t data;
    logic       last;
    logic       bub;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, errors = 0, bubbles = 0;

  dimc_feat_loader_if #(.DATA_W(DIMC_FEAT_W)) bus ();

  dimc_feat_loader dut (
    .dimc_tilewrap_clk (clk),
    .dimc_tilewrap_rst (rst),
    .soft_reset        (soft_reset),
    .disable_stall     (disable_stall),
    .feat_en           (feat_en),
    .tile_en           (tile_en),
    .valid_feat_count  (count),
    .bus               (bus),
    .feat_buff_full    (full),
    .feat_buff_empty   (empty),
    .feat_buff_level   (level),
    .busy              (busy),
    .done_pulse        (done),
    .err_underrun      (err)
`ifdef DIMC_FEAT_LOADER_STATS_EN
    ,
    .stat_words        (stat_words),
    .stat_bubbles      (stat_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: every handshake is matched against the next expected word
  always @(negedge clk) begin
    if (err) bubbles++;
    if (!rst && !soft_reset && bus.m_feat_valid && bus.m_feat_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", bus.m_feat_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", bus.m_feat_data, e.data);
        chk("word_last", {63'd0, bus.m_feat_last}, {63'd0, e.last});
        chk("word_underrun", {63'd0, err}, {63'd0, e.bub});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(feat_word_t d);
    bus.s_feat_valid = 1;
    bus.s_feat_data  = d;
    tick();
    bus.s_feat_valid = 0;
  endtask

  task automatic expect_word(feat_word_t d, logic last, logic bub);
    exp_q.push_back('{data: d, last: last, bub: bub});
  endtask

  task automatic start_pass(int n);
    count   = 8'(n);
    feat_en = 1;
    tile_en = 1;
    tick();
    count = 0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    chk({name, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bus.s_feat_valid = 0;
    bus.s_feat_data  = '0;
    bus.m_feat_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_valid", {63'd0, bus.m_feat_valid}, 64'd0);
    chk("rst_data", bus.m_feat_data, 64'd0);
    tick();
    rst = 0;

    // 1: four buffered words in order, last on A3
    for (int i = 0; i < 4; i++) push_word(64'hA0 + 64'(i));
    chk("t1_level", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) expect_word(64'hA0 + 64'(i), i == 3, 0);
    bus.m_feat_ready = 1;
    start_pass(4);
    wait_done("t1");
    chk("t1_empty", {63'd0, empty}, 64'd1);

    // 2: fill to full, 17th word refused, one pop clears full
    bus.m_feat_ready = 0;
    for (int i = 0; i < 16; i++) push_word(64'hB0 + 64'(i));
    chk("t2_full", {63'd0, full}, 64'd1);
    chk("t2_s_ready", {63'd0, bus.s_feat_ready}, 64'd0);
    chk("t2_level16", 64'(level), 64'd16);
    push_word(64'hEE);
    chk("t2_level_after_17th", 64'(level), 64'd16);
    expect_word(64'hB0, 1, 0);
    bus.m_feat_ready = 1;
    start_pass(1);
    tick();
    chk("t2_full_cleared", {63'd0, full}, 64'd0);
    chk("t2_level15", 64'(level), 64'd15);
    wait_done("t2");
    chk("t2_head", bus.m_feat_data, 64'hB1);
    soft_reset = 1;
    tick();
    soft_reset = 0;
    chk("t2_flushed", 64'(level), 64'd0);

    // 3: underrun bubbles with disable_stall, stall without it
    disable_stall = 1;
    bubbles = 0;
    push_word(64'hC0);
    expect_word(64'hC0, 0, 0);
    expect_word(64'h0, 0, 1);
    expect_word(64'h0, 1, 1);
    start_pass(3);
    wait_done("t3");
    chk("t3_bubbles", 64'(bubbles), 64'd2);
    disable_stall = 0;
    push_word(64'hC1);
    expect_word(64'hC1, 0, 0);
    start_pass(3);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", {63'd0, bus.m_feat_valid}, 64'd0);
    end
    chk("t3_stall_busy", {63'd0, busy}, 64'd1);
    tile_en = 0;
    tick();
    chk("t3_abort_busy", {63'd0, busy}, 64'd0);
    tile_en = 1;

    // 4: feat_en pause after two handshakes
    for (int i = 0; i < 5; i++) push_word(64'hD0 + 64'(i));
    for (int i = 0; i < 5; i++) expect_word(64'hD0 + 64'(i), i == 4, 0);
    start_pass(5);
    tick();
    tick();
    feat_en = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_pause_valid", {63'd0, bus.m_feat_valid}, 64'd0);
    end
    chk("t4_pause_level", 64'(level), 64'd3);
    feat_en = 1;
    wait_done("t4");

    // 5: tile_en abort after two handshakes keeps the rest buffered
    for (int i = 0; i < 6; i++) push_word(64'hF0 + 64'(i));
    expect_word(64'hF0, 0, 0);
    expect_word(64'hF1, 0, 0);
    start_pass(6);
    tick();
    tick();
    tile_en = 0;
    bus.m_feat_ready = 0;
    tick();
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_level", 64'(level), 64'd4);
    chk("t5_head", bus.m_feat_data, 64'hF2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_done", {63'd0, done}, 64'd0);
    end
    tile_en = 1;

    // 6: soft_reset mid-pass, then async reset mid-push
    for (int i = 0; i < 3; i++) push_word(64'h60 + 64'(i));
    chk("t6_level7", 64'(level), 64'd7);
    start_pass(8);
    chk("t6_busy", {63'd0, busy}, 64'd1);
    soft_reset = 1;
    bus.s_feat_valid = 1;
    bus.s_feat_data  = 64'h77;
    tick();
    soft_reset = 0;
    bus.s_feat_valid = 0;
    chk("t6_soft_level", 64'(level), 64'd0);
    chk("t6_soft_empty", {63'd0, empty}, 64'd1);
    chk("t6_soft_busy", {63'd0, busy}, 64'd0);
    feat_en = 0;
    bus.s_feat_valid = 1;
    bus.s_feat_data  = 64'h88;
    tick();
    tick();
    chk("t6_pre_async_level", 64'(level), 64'd2);
    #2 rst = 1;
    #1;
    chk("t6_async_level", 64'(level), 64'd0);
    chk("t6_async_empty", {63'd0, empty}, 64'd1);
    chk("t6_async_busy", {63'd0, busy}, 64'd0);
    bus.s_feat_valid = 0;
    tick();
    rst = 0;
    tick();
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
